alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command-issuing counterpart of alu8b. Holds a small loadable program of {opcode, a, b} entries and, on start, drives each entry onto the ALU's opcode/a/b inputs. After the configured ALU latency it captures z and streams out one indexed result per entry, then pulses done. Used for self-test and for scripted datapath bring-up, in place of a hand-written stimulus bench.

Parameters:
DEPTH, 8, number of program entries (power of 2, 2..16).
AW, 3, program address width, log2(DEPTH).
ALU_LAT, 1, clock edges from operands changing to z valid (0 = combinational ALU).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
prog_we  in  1  program write strobe
prog_addr  in  AW  program write address
prog_data  in  24  entry {opcode[23:16], a[15:8], b[7:0]}
prog_len  in  AW+1  number of entries to run, 0..DEPTH
start  in  1  begin run; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of run
opcode  out  8  to ALU opcode
a  out  8  to ALU a
b  out  8  to ALU b
z  in  8  from ALU result
res_valid  out  1  one-cycle result strobe
res_idx  out  AW  program index of res_data
res_data  out  8  captured z

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; busy=0, done=0, res_valid=0, res_idx=0, res_data=0, opcode=a=b=0, index and latency counters=0. Program memory is NOT cleared. rst overrides every other input, including mid-run; a run aborted by reset produces no further res_valid and no done.
- Program write: at an edge with prog_we=1 and state=IDLE, mem[prog_addr] <= prog_data. prog_we while busy is ignored. A write and start in the same cycle: the write takes effect, and the run uses the new contents.
- prog_len is latched when start is accepted. Values > DEPTH are clamped to DEPTH.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: if start=1 and latched len=0, go to FINISH. No operands are driven and no results are produced. If start=1 and len>0: idx<=0; opcode/a/b <= mem[0]; busy<=1; go to ISSUE (if ALU_LAT=0) or WAIT with cnt<=ALU_LAT-1 (if ALU_LAT>0).
- WAIT: cnt decrements each cycle. Go to ISSUE when cnt=0.
- ISSUE (capture edge): res_data<=z, res_idx<=idx, res_valid<=1 for exactly one cycle.
  - If idx=len-1, go to FINISH.
  - Otherwise idx<=idx+1, opcode/a/b <= mem[idx+1] on the same edge, and re-enter the WAIT/ISSUE path.
- Timing: operands for entry k update at edge E_k. z is sampled at edge E_k+ALU_LAT+1. Entry k+1 operands update at that same edge. Throughput is one op per ALU_LAT+1 cycles. First operands appear one cycle after start is sampled.
- FINISH: done=1 and busy=0 for one cycle. opcode/a/b hold the last driven values. Then return to IDLE.
- start while not IDLE is ignored; there is no queuing.
- res_valid never asserts in two consecutive cycles unless ALU_LAT=0.
- Index wraps never occur; idx is bounded by len-1.

Test Plan:
Bench ALU model for all scenarios: registered z = a+b, ALU_LAT=1.
1. Reset then idle: rst=1 for 2 cycles, then release with no start -> all outputs 0, busy=0, done never pulses.
2. Basic run: load entries {63,0F,07}, {79,0F,07}, {8A,01,07}, prog_len=3, pulse start -> opcode 63/79/8A each held 2 cycles. res_valid pulses with (idx, data) = (0,16), (1,16), (2,08). busy=1 throughout. done pulses exactly 1 cycle after the last res_valid.
3. Empty program: prog_len=0, start -> done pulses on the next cycle, no res_valid, opcode/a/b stay 0.
4. Ignored inputs while busy: during scenario 2, assert start and prog_we addr 1 = {00,FF,FF} -> the run is unaffected. Memory entry 1 still produces 16 on a rerun.
5. Reset mid-run: assert rst the cycle after the first res_valid -> no further res_valid, no done, outputs return to 0. A following start reruns from idx 0 with the correct results.
6. Full depth plus ALU_LAT=0: prog_len=8 with a combinational ALU model -> res_valid on 8 consecutive cycles with idx 0..7, then done. Also set prog_len=15 -> clamped to 8 results.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: replays a loaded {opcode,a,b} program into an ALU
// and streams back one indexed z capture per entry.
module alu_op_sequencer #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int ALU_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [23:0]   prog_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [7:0]    opcode,
   output logic [7:0]    a,
   output logic [7:0]    b,
   input  logic [7:0]    z,
   output logic          res_valid,
   output logic [AW-1:0] res_idx,
   output logic [7:0]    res_data
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      FINISH
   } state_t;

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      CW'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);
   localparam state_t OP_STATE = (ALU_LAT == 0) ? ISSUE : WAIT;
   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   state_t        state;
   logic [23:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [AW-1:0] idx_nx;
   logic [AW:0]   len;
   logic [AW:0]   len_in;
   logic [CW-1:0] cnt;
   logic [23:0]   first_entry;
   logic          last;
   logic          wr_en;

   assign wr_en  = prog_we && (state == IDLE) && !rst;
   assign idx_nx = idx + 1'b1;
   assign len_in = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
   assign last   = ({1'b0, idx} == (len - 1'b1));

   // a same-cycle write to entry 0 must be seen by the run it starts
   assign first_entry = (wr_en && prog_addr == '0) ? prog_data : mem[0];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         res_valid <= 1'b0;
         res_idx   <= '0;
         res_data  <= '0;
         opcode    <= '0;
         a         <= '0;
         b         <= '0;
         idx       <= '0;
         cnt       <= '0;
         len       <= '0;
      end else begin
         res_valid <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  len <= len_in;
                  if (len_in == '0) begin
                     state <= FINISH;
                  end else begin
                     idx            <= '0;
                     {opcode, a, b} <= first_entry;
                     busy           <= 1'b1;
                     cnt            <= CNT_INIT;
                     state          <= OP_STATE;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0)
                  state <= ISSUE;
               else
                  cnt <= cnt - 1'b1;
            end
            ISSUE: begin
               res_data  <= z;
               res_idx   <= idx;
               res_valid <= 1'b1;
               if (last) begin
                  state <= FINISH;
               end else begin
                  idx            <= idx_nx;
                  {opcode, a, b} <= mem[idx_nx];
                  cnt            <= CNT_INIT;
                  state          <= OP_STATE;
               end
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: registered adder ALU (ALU_LAT=1) and a
// combinational adder ALU (ALU_LAT=0) instance.
module tb_alu_op_sequencer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [23:0]   prog_data = '0;
   logic [AW:0]   prog_len = '0;
   logic          start1 = 1'b0;
   logic          start0 = 1'b0;

   logic          busy1, done1, rv1;
   logic [7:0]    op1, a1, b1, z1, rd1;
   logic [AW-1:0] ri1;
   logic          busy0, done0, rv0;
   logic [7:0]    op0, a0, b0, z0, rd0;
   logic [AW-1:0] ri0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) z1 <= a1 + b1;
   assign z0 = a0 + b0;

   alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW), .ALU_LAT(1)) u1 (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start1),
      .busy(busy1), .done(done1), .opcode(op1), .a(a1), .b(b1),
      .z(z1), .res_valid(rv1), .res_idx(ri1), .res_data(rd1)
   );

   alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW), .ALU_LAT(0)) u0 (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start0),
      .busy(busy0), .done(done0), .opcode(op0), .a(a0), .b(b0),
      .z(z0), .res_valid(rv0), .res_idx(ri0), .res_data(rd0)
   );

   typedef struct {
      logic          start;
      logic          we;
      logic [AW-1:0] addr;
      logic [23:0]   data;
      logic          busy;
      logic          done;
      logic          rv;
      logic [AW-1:0] idx;
      logic [7:0]    res;
      logic [7:0]    op;
   } vec_t;

   vec_t tv [9];

   logic [7:0] got [DEPTH];
   int         got_n;
   int         got_done;
   int         timed_out;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] ad, input logic [23:0] d);
      prog_we   = 1'b1;
      prog_addr = ad;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic run1_collect();
      got_n     = 0;
      got_done  = 0;
      timed_out = 1;
      for (int i = 0; i < DEPTH; i++) got[i] = 8'hxx;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (rv1) begin
            got[ri1] = rd1;
            got_n++;
         end
         if (done1) begin
            got_done  = 1;
            timed_out = 0;
            break;
         end
         tick();
      end
   endtask

   task automatic lat0_run(input logic [AW:0] len, input string tag);
      prog_len = len;
      start0   = 1'b1;
      tick();
      start0   = 1'b0;
      chk({tag, "_rv0"}, 32'(rv0), 32'd0);
      chk({tag, "_op0"}, 32'(op0), 32'hA0);
      for (int k = 1; k <= DEPTH; k++) begin
         tick();
         chk({tag, "_rv"}, 32'(rv0), 32'd1);
         chk({tag, "_idx"}, 32'(ri0), 32'(k - 1));
         chk({tag, "_res"}, 32'(rd0), 32'(8'(17 * (k - 1))));
         chk({tag, "_busy"}, 32'(busy0), 32'd1);
      end
      tick();
      chk({tag, "_done"}, 32'(done0), 32'd1);
      chk({tag, "_rvend"}, 32'(rv0), 32'd0);
      chk({tag, "_busyend"}, 32'(busy0), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'(done0), 32'd0);
   endtask

   initial begin
      int quiet;

      tv[0] = '{1'b1, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0,
                8'h00, 8'h63};
      tv[1] = '{1'b0, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0,
                8'h00, 8'h63};
      tv[2] = '{1'b1, 1'b1, 3'd1, 24'h00FFFF, 1'b1, 1'b0, 1'b1, 3'd0,
                8'h16, 8'h79};
      tv[3] = '{1'b0, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0,
                8'h00, 8'h79};
      tv[4] = '{1'b0, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b1, 3'd1,
                8'h16, 8'h8A};
      tv[5] = '{1'b0, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b0, 3'd0,
                8'h00, 8'h8A};
      tv[6] = '{1'b0, 1'b0, 3'd0, 24'h0, 1'b1, 1'b0, 1'b1, 3'd2,
                8'h08, 8'h8A};
      tv[7] = '{1'b0, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1, 1'b0, 3'd0,
                8'h00, 8'h8A};
      tv[8] = '{1'b0, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0, 1'b0, 3'd0,
                8'h00, 8'h8A};

      // reset, then idle with no start
      rst = 1'b1;
      tick();
      tick();
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_rv", 32'(rv1), 32'd0);
      chk("rst_idx", 32'(ri1), 32'd0);
      chk("rst_data", 32'(rd1), 32'd0);
      chk("rst_opab", {8'h0, op1, a1, b1}, 32'd0);
      rst = 1'b0;
      quiet = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done1 || busy1 || rv1) quiet++;
      end
      chk("idle_quiet", 32'(quiet), 32'd0);

      // empty program
      prog_len = '0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("empty_done_e0", 32'(done1), 32'd0);
      chk("empty_busy_e0", 32'(busy1), 32'd0);
      tick();
      chk("empty_done", 32'(done1), 32'd1);
      chk("empty_busy", 32'(busy1), 32'd0);
      chk("empty_rv", 32'(rv1), 32'd0);
      chk("empty_opab", {8'h0, op1, a1, b1}, 32'd0);
      tick();
      chk("empty_done_pulse", 32'(done1), 32'd0);

      // basic run with ignored start/prog_we mid-run
      wr(3'd0, 24'h630F07);
      wr(3'd1, 24'h790F07);
      wr(3'd2, 24'h8A0107);
      prog_len = 4'd3;
      for (int k = 0; k < 9; k++) begin
         start1    = tv[k].start;
         prog_we   = tv[k].we;
         prog_addr = tv[k].addr;
         prog_data = tv[k].data;
         tick();
         chk($sformatf("v%0d_busy", k), 32'(busy1), 32'(tv[k].busy));
         chk($sformatf("v%0d_done", k), 32'(done1), 32'(tv[k].done));
         chk($sformatf("v%0d_rv", k), 32'(rv1), 32'(tv[k].rv));
         chk($sformatf("v%0d_op", k), 32'(op1), 32'(tv[k].op));
         if (tv[k].rv) begin
            chk($sformatf("v%0d_idx", k), 32'(ri1), 32'(tv[k].idx));
            chk($sformatf("v%0d_res", k), 32'(rd1), 32'(tv[k].res));
         end
         if (k == 0) chk("v0_ab", {16'h0, a1, b1}, 32'h0F07);
      end
      start1  = 1'b0;
      prog_we = 1'b0;

      // rerun: entry 1 must be unchanged by the ignored write
      run1_collect();
      chk("rerun_timeout", 32'(timed_out), 32'd0);
      chk("rerun_n", 32'(got_n), 32'd3);
      chk("rerun_r0", 32'(got[0]), 32'h16);
      chk("rerun_r1", 32'(got[1]), 32'h16);
      chk("rerun_r2", 32'(got[2]), 32'h08);
      tick();

      // reset the cycle after the first result
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      timed_out = 1;
      for (int c = 0; c < 10; c++) begin
         if (rv1) begin
            timed_out = 0;
            break;
         end
         tick();
      end
      chk("abort_first_rv", 32'(timed_out), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_rv", 32'(rv1), 32'd0);
      chk("abort_opab", {8'h0, op1, a1, b1}, 32'd0);
      chk("abort_res", {21'h0, ri1, rd1}, 32'd0);
      quiet = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done1 || rv1 || busy1) quiet++;
      end
      chk("abort_quiet", 32'(quiet), 32'd0);
      run1_collect();
      chk("after_abort_timeout", 32'(timed_out), 32'd0);
      chk("after_abort_n", 32'(got_n), 32'd3);
      chk("after_abort_r0", 32'(got[0]), 32'h16);
      chk("after_abort_r1", 32'(got[1]), 32'h16);
      chk("after_abort_r2", 32'(got[2]), 32'h08);
      tick();

      // full depth with a combinational ALU, then clamped length
      for (int i = 0; i < DEPTH; i++)
         wr(AW'(i), {8'(8'hA0 + i), 8'(16 * i), 8'(i)});
      lat0_run(4'd8, "full");
      lat0_run(4'd15, "clamp");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
